// File: rtl/cnt_share_pkg.sv
// cnt_share_pkg: shared command/state encodings and default sizes for the shared counter controller.
package cnt_share_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 9;
    typedef enum logic [1:0] {CMD_INC, CMD_DEC, CMD_CLR, CMD_LOAD} cmd_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_EXEC} state_e;
endpackage

// File: rtl/cnt_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i and wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan farthest-first so the nearest requester at/after the pointer wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                idx_o   = IW'((int'(ptr_i) + k) % N_REQ);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cnt_share_ctrl.sv
// cnt_share_ctrl: arbitrates a shared up/down counter among requesters, one command per 3-cycle transaction.
module cnt_share_ctrl
    import cnt_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst1_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     cmd,
    input  logic [CNT_W*N_REQ-1:0] load_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [CNT_W-1:0]       count,
    output logic                   busy,
    output logic                   wrap,
    output logic                   uflow
);
    localparam int IW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, gidx_q, gidx_d, arb_idx;
    logic             arb_valid;
    logic [CNT_W-1:0] count_q, count_d, sel_ld;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             wrap_q, wrap_d, uflow_q, uflow_d;
    cmd_e             sel_cmd;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    assign sel_cmd = cmd_e'(cmd[{gidx_q, 1'b0} +: 2]);
    assign sel_ld  = load_data[CNT_W*gidx_q +: CNT_W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        count_d = count_q;
        gnt_d   = '0;
        wrap_d  = 1'b0;
        uflow_d = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = |req ? ST_ARB : ST_IDLE;
            ST_ARB: begin
                state_d = arb_valid ? ST_EXEC : ST_IDLE;
                gidx_d  = arb_valid ? arb_idx : gidx_q;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                // A requester that withdrew before EXEC is cancelled without side effects.
                if (req[gidx_q]) begin
                    count_d = sel_cmd == CMD_INC ? count_q + 1'b1 :
                              sel_cmd == CMD_DEC ? count_q - 1'b1 :
                              sel_cmd == CMD_CLR ? '0 : sel_ld;
                    wrap_d  = sel_cmd == CMD_INC && count_q == '1;
                    uflow_d = sel_cmd == CMD_DEC && count_q == '0;
                    gnt_d[gidx_q] = 1'b1;
                    ptr_d   = gidx_q == IW'(N_REQ - 1) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            wrap_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            wrap_q  <= wrap_d;
            uflow_q <= uflow_d;
        end
    end

    assign gnt   = gnt_q;
    assign count = count_q;
    assign busy  = state_q != ST_IDLE;
    assign wrap  = wrap_q;
    assign uflow = uflow_q;
endmodule

// File: tb/tb_cnt_share_ctrl.sv
// tb_cnt_share_ctrl: directed stimulus with a gnt-driven scoreboard for cnt_share_ctrl.
module tb_cnt_share_ctrl;
    import cnt_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst1_n;
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [35:0] load_data;
    logic [3:0]  gnt;
    logic [8:0]  count;
    logic        busy, wrap, uflow;

    typedef struct {
        int         idx;
        logic [8:0] cnt;
        logic       w;
        logic       u;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cnt_share_ctrl dut (
        .clk      (clk),
        .rst1_n   (rst1_n),
        .req      (req),
        .cmd      (cmd),
        .load_data(load_data),
        .gnt      (gnt),
        .count    (count),
        .busy     (busy),
        .wrap     (wrap),
        .uflow    (uflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req_v);
        end
    endtask

    // Advance to the next falling edge; requesters drop req once granted.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [8:0] d);
        cmd[2*i +: 2]       = c;
        load_data[9*i +: 9] = d;
        req[i]              = 1'b1;
    endtask

    task automatic push(input int i, input logic [8:0] c, input logic w, input logic u);
        exp_t e;
        e.idx = i;
        e.cnt = c;
        e.w   = w;
        e.u   = u;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (req == 4'b0 && !busy && exp_q.size() == 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_done: timeout, req=%b busy=%b pending=%0d", req, busy, exp_q.size());
    endtask

    task automatic pulse_reset();
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        tick();
    endtask

    // Monitor: every gnt pops the oldest expectation; strobes must never appear without gnt.
    initial begin
        forever begin
            @(negedge clk);
            if (rst1_n && gnt != 4'b0) begin
                exp_t e;
                chk("gnt_onehot", $countones(gnt), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: gnt=%b with nothing pending", gnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_idx", 32'(gnt), 32'(4'b1 << e.idx));
                    chk("gnt_count", 32'(count), 32'(e.cnt));
                    chk("gnt_wrap", 32'(wrap), 32'(e.w));
                    chk("gnt_uflow", 32'(uflow), 32'(e.u));
                end
            end else if (rst1_n) begin
                chk("idle_strobes", {30'b0, wrap, uflow}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst1_n    = 1'b0;
        req       = '0;
        cmd       = '0;
        load_data = '0;
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {30'b0, wrap, uflow}, 0);
        rst1_n = 1'b1;
        tick();

        // Single requester: gnt three edges after req is seen in IDLE.
        set_req(0, CMD_INC, 9'd0);
        push(0, 9'd1, 1'b0, 1'b0);
        tick();
        chk("lat_busy1", 32'(busy), 1);
        chk("lat_gnt1", 32'(gnt), 0);
        tick();
        chk("lat_busy2", 32'(busy), 1);
        chk("lat_gnt2", 32'(gnt), 0);
        tick();
        chk("lat_gnt3", 32'(gnt), 32'(4'b0001));
        chk("lat_count3", 32'(count), 1);
        chk("lat_busy3", 32'(busy), 0);
        wait_done(20);

        // Contention from a fresh reset: rotation 0,1,2,3.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, CMD_INC, 9'd0);
            push(i, 9'(i + 1), 1'b0, 1'b0);
        end
        wait_done(60);
        chk("cont_count", 32'(count), 4);

        // Pointer back at 0: requester 0 beats requester 3.
        set_req(0, CMD_INC, 9'd0);
        set_req(3, CMD_INC, 9'd0);
        push(0, 9'd5, 1'b0, 1'b0);
        push(3, 9'd6, 1'b0, 1'b0);
        wait_done(30);

        // Load, wrap on INC, underflow on DEC.
        set_req(2, CMD_LOAD, 9'd511);
        push(2, 9'd511, 1'b0, 1'b0);
        wait_done(20);
        set_req(2, CMD_INC, 9'd0);
        push(2, 9'd0, 1'b1, 1'b0);
        wait_done(20);
        set_req(2, CMD_DEC, 9'd0);
        push(2, 9'd511, 1'b0, 1'b1);
        wait_done(20);

        // Withdrawal during ARB: no grant, pointer stays at 3.
        set_req(1, CMD_INC, 9'd0);
        tick();
        req[1] = 1'b0;
        tick();
        chk("wd_busy", 32'(busy), 0);
        chk("wd_gnt", 32'(gnt), 0);
        tick();
        chk("wd_count", 32'(count), 511);
        set_req(1, CMD_INC, 9'd0);
        set_req(2, CMD_INC, 9'd0);
        push(1, 9'd0, 1'b1, 1'b0);
        push(2, 9'd1, 1'b0, 1'b0);
        wait_done(30);

        // Reset while a LOAD 300 is in EXEC.
        set_req(2, CMD_LOAD, 9'd300);
        tick();
        tick();
        rst1_n = 1'b0;
        req    = '0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        tick();
        rst1_n = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk("post_rst_count", 32'(count), 0);

        // Move pointer to 2, then CLR from 0 wins over 1 and 1 follows.
        set_req(1, CMD_INC, 9'd0);
        push(1, 9'd1, 1'b0, 1'b0);
        wait_done(20);
        set_req(0, CMD_CLR, 9'd0);
        set_req(1, CMD_INC, 9'd0);
        push(0, 9'd0, 1'b0, 1'b0);
        push(1, 9'd1, 1'b0, 1'b0);
        wait_done(30);

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
